// File: rtl/sha256_word_packer.sv
// Packs a length-headed stream of IN_W-bit big-endian words into 512-bit blocks, one cfg beat per message.
// Optional `SHA256_WORD_PACKER_LAST_CHECK_EN flags word_in_last disagreements with the header length in err_last.
module sha256_word_packer #(
   parameter int          IN_W   = 32,
   parameter logic [1:0]  SCHEME = 2'b00
) (
   input  logic              clk,
   input  logic              sync_rst,
   input  logic              en,
   input  logic [63:0]       hdr_len,
   input  logic              hdr_valid,
   output logic              hdr_ready,
   input  logic [IN_W-1:0]   word_in,
   input  logic              word_in_last,
   input  logic              word_in_valid,
   output logic              word_in_ready,
   output logic [511:0]      data_out,
   output logic              data_out_last,
   output logic              data_out_valid,
   input  logic              data_out_ready,
   output logic [63:0]       cfg_size,
   output logic [1:0]        cfg_scheme,
   output logic              cfg_last,
   output logic              cfg_valid,
   input  logic              cfg_ready,
   output logic              err_last,
   output logic [1:0]        dbg_state
);

   localparam int DATA_W = 512;
   localparam int WORDS  = DATA_W / IN_W;
   localparam int BYTES  = IN_W / 8;

   typedef enum logic [1:0] {S_IDLE, S_CFG, S_FILL, S_SEND} state_t;

   // Handshake: a beat moves on a rising edge where valid, ready and en are all high.
   state_t        state;
   logic [63:0]   remaining;
   logic [4:0]    wcnt;
   logic [63:0]   take;
   logic          final_word;
   logic          block_full;
   logic          word_fire;
   logic [IN_W-1:0] word_masked;

   assign hdr_ready      = en && (state == S_IDLE);
   assign cfg_valid      = en && (state == S_CFG);
   assign word_in_ready  = en && (state == S_FILL);
   assign data_out_valid = en && (state == S_SEND);
   assign cfg_scheme     = SCHEME;
   assign cfg_last       = 1'b1;
   assign dbg_state      = state;
   assign word_fire      = word_in_valid && word_in_ready;

   always_comb begin
      final_word  = (remaining <= 64'(BYTES));
      take        = final_word ? remaining : 64'(BYTES);
      block_full  = (wcnt == 5'(WORDS - 1));
      word_masked = word_in;
      // Bytes beyond the message length are zeroed; byte 0 is the MSB byte.
      for (int b = 0; b < BYTES; b++) begin
         if (64'(b) >= remaining) word_masked[IN_W-1-8*b -: 8] = 8'h00;
      end
   end

   always_ff @(posedge clk) begin
      if (sync_rst) begin
         state         <= S_IDLE;
         remaining     <= '0;
         wcnt          <= '0;
         data_out      <= '0;
         data_out_last <= 1'b0;
         cfg_size      <= '0;
      end else if (en) begin
         case (state)
            S_IDLE: begin
               if (hdr_valid) begin
                  state     <= S_CFG;
                  remaining <= hdr_len;
                  cfg_size  <= {hdr_len[60:0], 3'b000};
               end
            end
            S_CFG: begin
               if (cfg_ready) begin
                  if (remaining == 64'd0) begin
                     state         <= S_SEND;
                     data_out_last <= 1'b1;
                  end else begin
                     state <= S_FILL;
                  end
               end
            end
            S_FILL: begin
               if (word_in_valid) begin
                  data_out[DATA_W-1-IN_W*int'(wcnt) -: IN_W] <= word_masked;
                  wcnt      <= wcnt + 5'd1;
                  remaining <= remaining - take;
                  if (final_word || block_full) begin
                     state         <= S_SEND;
                     data_out_last <= final_word;
                  end
               end
            end
            S_SEND: begin
               if (data_out_ready) begin
                  // Clearing here keeps unwritten slots of the next block at zero.
                  data_out      <= '0;
                  wcnt          <= '0;
                  data_out_last <= 1'b0;
                  state         <= data_out_last ? S_IDLE : S_FILL;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef SHA256_WORD_PACKER_LAST_CHECK_EN
   always_ff @(posedge clk) begin
      if (sync_rst) err_last <= 1'b0;
      else if (word_fire && (word_in_last != final_word)) err_last <= 1'b1;
   end
`else
   // The marker is ignored in this build; the AND keeps the input referenced.
   assign err_last = 1'b0 & word_in_last & word_fire;
`endif

endmodule

// File: tb/tb_sha256_word_packer.sv
// Scoreboard bench for sha256_word_packer (IN_W=32): expected cfg beats and blocks queued at drive time.
module tb_sha256_word_packer;

   localparam logic [1:0] SCH = 2'b10;

   logic          clk = 1'b0;
   logic          sync_rst = 1'b1;
   logic          en = 1'b1;
   logic [63:0]   hdr_len = '0;
   logic          hdr_valid = 1'b0;
   logic          hdr_ready;
   logic [31:0]   word_in = '0;
   logic          word_in_last = 1'b0;
   logic          word_in_valid = 1'b0;
   logic          word_in_ready;
   logic [511:0]  data_out;
   logic          data_out_last;
   logic          data_out_valid;
   logic          data_out_ready = 1'b1;
   logic [63:0]   cfg_size;
   logic [1:0]    cfg_scheme;
   logic          cfg_last;
   logic          cfg_valid;
   logic          cfg_ready = 1'b1;
   logic          err_last;
   logic [1:0]    dbg_state;

   sha256_word_packer #(.IN_W(32), .SCHEME(SCH)) dut (
      .clk(clk), .sync_rst(sync_rst), .en(en),
      .hdr_len(hdr_len), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
      .word_in(word_in), .word_in_last(word_in_last),
      .word_in_valid(word_in_valid), .word_in_ready(word_in_ready),
      .data_out(data_out), .data_out_last(data_out_last),
      .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
      .cfg_size(cfg_size), .cfg_scheme(cfg_scheme), .cfg_last(cfg_last),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .err_last(err_last), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   int            n_tests = 0;
   int            n_fail  = 0;
   int            wr_seen = 0;
   int            bad_idx = -1;
   logic          zero_chk = 1'b0;
   logic [31:0]   msg_words [0:31];
   logic [512:0]  exp_blk_q [$];
   logic [63:0]   exp_cfg_q [$];

`ifdef SHA256_WORD_PACKER_LAST_CHECK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   task automatic check(input string tag, input logic [512:0] obs, input logic [512:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // reference model for one block of a message
   function automatic logic [512:0] model_block(int len, int b, int nb);
      logic [511:0] d;
      logic [31:0]  wd;
      int           w, off, keep;
      d = '0;
      for (int s = 0; s < 16; s++) begin
         w   = b * 16 + s;
         off = w * 4;
         if (off < len) begin
            wd   = msg_words[w];
            keep = len - off;
            for (int k = 0; k < 4; k++) if (k >= keep) wd[31-8*k -: 8] = 8'h00;
            d[511-32*s -: 32] = wd;
         end
      end
      return {(b == nb - 1), d};
   endfunction

   task automatic push_expected(input int len);
      int nb;
      exp_cfg_q.push_back(64'(len) * 64'd8);
      nb = (len == 0) ? 1 : (len + 63) / 64;
      for (int b = 0; b < nb; b++) exp_blk_q.push_back(model_block(len, b, nb));
   endtask

   // driver tasks: called at posedge+1, return at posedge+1
   task automatic send_hdr(input int len);
      logic ok;
      ok = 1'b0;
      hdr_len   = 64'(len);
      hdr_valid = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = hdr_ready;
         @(posedge clk); #1;
      end
      hdr_valid = 1'b0;
      if (!ok) check("hdr_timeout", 0, 1);
   endtask

   task automatic run_words(input int n);
      logic ok;
      for (int w = 0; w < n; w++) begin
         ok = 1'b0;
         word_in       = msg_words[w];
         word_in_last  = (w == n - 1) ^ (w == bad_idx);
         word_in_valid = 1'b1;
         for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = word_in_ready;
            @(posedge clk); #1;
         end
         if (!ok) check("word_timeout", 0, 1);
      end
      word_in_valid = 1'b0;
      word_in_last  = 1'b0;
   endtask

   task automatic wait_drain();
      int i;
      i = 0;
      while ((exp_blk_q.size() != 0 || exp_cfg_q.size() != 0) && i < 500) begin
         @(negedge clk);
         i++;
      end
      if (i >= 500) check("drain_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   // scoreboard / monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (zero_chk) begin
         check("zero_blk_latency", data_out_valid, 1);
         zero_chk = 1'b0;
      end
      if (word_in_ready) wr_seen++;
      if (data_out_valid) check("wr_in_send", word_in_ready, 0);
      if (!sync_rst && cfg_valid && cfg_ready) begin
         if (exp_cfg_q.size() == 0) check("unexp_cfg", 1, 0);
         else begin
            logic [63:0] e;
            e = exp_cfg_q.pop_front();
            check("cfg_size", cfg_size, e);
            check("cfg_scheme", cfg_scheme, SCH);
            check("cfg_last", cfg_last, 1);
            if (e == 64'd0) zero_chk = 1'b1;
         end
      end
      if (!sync_rst && data_out_valid && data_out_ready) begin
         if (exp_blk_q.size() == 0) check("unexp_blk", 1, 0);
         else check("block", {data_out_last, data_out}, exp_blk_q.pop_front());
      end
   end

   initial begin
      // reset values
      @(posedge clk); @(posedge clk); #1;
      sync_rst = 1'b0;
      @(negedge clk);
      check("rst_hdr_ready", hdr_ready, 1);
      check("rst_cfg_valid", cfg_valid, 0);
      check("rst_wr", word_in_ready, 0);
      check("rst_dv", data_out_valid, 0);
      check("rst_data", {data_out_last, data_out}, 0);
      check("rst_cfg_size", cfg_size, 0);
      check("rst_err", err_last, 0);
      check("rst_state", dbg_state, 0);
      @(posedge clk); #1;

      // 3-byte message, partial final word
      msg_words[0] = 32'hAABBCCDD;
      push_expected(3);
      send_hdr(3);
      run_words(1);
      wait_drain();

      // exactly one full block
      for (int i = 0; i < 16; i++) msg_words[i] = 32'(i);
      push_expected(64);
      send_hdr(64);
      run_words(16);
      wait_drain();
      @(negedge clk);
      check("idle_after_64", hdr_ready, 1);
      @(posedge clk); #1;

      // two blocks, second partial
      for (int i = 0; i < 32; i++) msg_words[i] = $urandom;
      push_expected(100);
      send_hdr(100);
      run_words(25);
      wait_drain();

      // zero-length message
      push_expected(0);
      wr_seen = 0;
      send_hdr(0);
      wait_drain();
      check("zero_no_wr", wr_seen, 0);

      // backpressure on cfg, then on data, then clock-enable low
      for (int i = 0; i < 16; i++) msg_words[i] = $urandom;
      push_expected(64);
      cfg_ready = 1'b0;
      send_hdr(64);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_cfg_valid", cfg_valid, 1);
         check("bp_cfg_size", cfg_size, 64'd512);
         check("bp_cfg_wr", word_in_ready, 0);
      end
      @(posedge clk); #1;
      cfg_ready      = 1'b1;
      data_out_ready = 1'b0;
      run_words(16);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_dv", data_out_valid, 1);
         check("bp_data", {data_out_last, data_out}, exp_blk_q[0]);
      end
      @(posedge clk); #1;
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("en_off_valids", {hdr_ready, cfg_valid, word_in_ready, data_out_valid}, 0);
         check("en_off_state", dbg_state, 3);
      end
      @(posedge clk); #1;
      en = 1'b1;
      data_out_ready = 1'b1;
      wait_drain();

      // reset mid-message, partial block discarded
      for (int i = 0; i < 16; i++) msg_words[i] = $urandom;
      exp_cfg_q.push_back(64'd512);
      send_hdr(64);
      run_words(5);
      sync_rst = 1'b1;
      @(posedge clk); #1;
      sync_rst = 1'b0;
      @(negedge clk);
      check("mid_rst_state", dbg_state, 0);
      check("mid_rst_valids", {cfg_valid, word_in_ready, data_out_valid}, 0);
      check("mid_rst_hdr_ready", hdr_ready, 1);
      @(posedge clk); #1;
      msg_words[0] = 32'h01020304;
      push_expected(4);
      send_hdr(4);
      run_words(1);
      wait_drain();

      // wrong end-of-message marker on word 1 of 3
      for (int i = 0; i < 3; i++) msg_words[i] = $urandom;
      push_expected(12);
      bad_idx = 1;
      send_hdr(12);
      run_words(3);
      bad_idx = -1;
      wait_drain();
      @(negedge clk);
      check("err_set", err_last, EXP_ERR);
      @(posedge clk); #1;
      msg_words[0] = $urandom;
      push_expected(4);
      send_hdr(4);
      run_words(1);
      wait_drain();
      @(negedge clk);
      check("err_sticky", err_last, EXP_ERR);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
